seven_segment_monitor: RTL

- Receive-side checker for the seven-segment counter output bus.
- Samples the 7-bit segment pattern and decodes it back to a BCD digit.
- Verifies that digits advance 0→1→…→9→0 and that each change arrives once every COMPARE clocks.
- Instanced in the top-level testbench/FPGA harness alongside the counter; flags are routed to debug LEDs or logic analyser.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/seven_segment_monitor.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display producers and consumers:
// segment encodings (bit0=a .. bit6=g, 1=lit), digit type and the
// monitor's tracking states.
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    SYNC,
    ACQUIRE,
    TRACK
  } state_t;

  localparam seg_t SEG_0 = 7'h3F;  // abcdef
  localparam seg_t SEG_1 = 7'h06;  // bc
  localparam seg_t SEG_2 = 7'h5B;  // abdeg
  localparam seg_t SEG_3 = 7'h4F;  // abcdg
  localparam seg_t SEG_4 = 7'h66;  // bcfg
  localparam seg_t SEG_5 = 7'h6D;  // acdfg
  localparam seg_t SEG_6 = 7'h7D;  // acdefg
  localparam seg_t SEG_7 = 7'h07;  // abc
  localparam seg_t SEG_8 = 7'h7F;  // abcdefg
  localparam seg_t SEG_9 = 7'h6F;  // abcdfg

  localparam seg_t SEG_ARRAY [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
    SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  // Successor in the 0..9 counting sequence; 9 wraps to 0.
  function automatic digit_t next_digit(input digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder. Only the ten canonical digit
// patterns are legal; anything else (blank, partial, extra segments) is
// reported as illegal with digit_o forced to 0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] led_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  // Match the pattern against the ten legal encodings.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    digit_o = '0;
    legal_o = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (led_i == SEG_ARRAY[i]) begin
        digit_o = digit_t'(i);
        legal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// Receive-side checker for a seven-segment counter bus. Decodes each sampled
// pattern, checks that digits step 0..9 with wrap, counts in-sequence
// changes and raises sticky flags for illegal patterns, out-of-order steps
// and (optionally) change intervals outside COMPARE +/- TOLERANCE clocks.
// Build option: define SEVEN_SEGMENT_MONITOR_TIMING_EN to include the
// interval counter and timing_error; otherwise timing_error is tied low.
module seven_segment_monitor
  import seg7_pkg::*;
#(
  parameter int COMPARE   = 16_000_000,
  parameter int TOLERANCE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  led_in,
  input  logic        err_clear,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        change,
  output logic [15:0] seconds,
  output logic        bad_pattern,
  output logic        seq_error,
  output logic        timing_error
);

  // Intervals must be at least one clock and the window must not go negative.
  if (COMPARE < 1 || TOLERANCE < 0 || TOLERANCE >= COMPARE) begin : g_param_check
    $error("seven_segment_monitor: requires 0 <= TOLERANCE < COMPARE");
  end

  state_t        state_q, state_d;
  digit_t        digit_q, digit_d;   // doubles as the previous valid digit
  logic          valid_q, valid_d;
  logic          change_q, change_d;
  logic [15:0]   seconds_q, seconds_d;
  logic          bad_q, bad_d, bad_set;
  logic          seq_q, seq_d, seq_set;

  digit_t        dec_digit;
  logic          dec_legal;
  logic          change_evt;
  logic          in_seq;

  seg7_decode u_decode (
    .led_i   (led_in),
    .digit_o (dec_digit),
    .legal_o (dec_legal)
  );

  // A change only counts once a baseline digit exists (i.e. outside SYNC).
  assign change_evt = dec_legal && (state_q != SYNC) && (dec_digit != digit_q);
  assign in_seq     = (dec_digit == next_digit(digit_q));

  // Sequence tracker: next state, decoded outputs and sticky pattern/sequence flags.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    valid_d   = dec_legal;
    change_d  = 1'b0;
    seconds_d = seconds_q;
    bad_set   = 1'b0;
    seq_set   = 1'b0;

    if (!dec_legal) begin
      bad_set = 1'b1;
      state_d = SYNC;
    end else begin
      digit_d = dec_digit;
      case (state_q)
        SYNC: state_d = ACQUIRE;
        ACQUIRE, TRACK: begin
          if (change_evt) begin
            change_d = 1'b1;
            if (in_seq) begin
              if (seconds_q != 16'hFFFF) seconds_d = seconds_q + 16'd1;
              state_d = TRACK;
            end else begin
              seq_set = 1'b1;
              state_d = ACQUIRE;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end

    // A set condition in the same cycle outranks err_clear.
    bad_d = bad_set | (bad_q & ~err_clear);
    seq_d = seq_set | (seq_q & ~err_clear);
  end

  // State and output registers; reset restores the SYNC baseline.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= SYNC;
      digit_q   <= '0;
      valid_q   <= 1'b0;
      change_q  <= 1'b0;
      seconds_q <= '0;
      bad_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      change_q  <= change_d;
      seconds_q <= seconds_d;
      bad_q     <= bad_d;
      seq_q     <= seq_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign change      = change_q;
  assign seconds     = seconds_q;
  assign bad_pattern = bad_q;
  assign seq_error   = seq_q;

`ifdef SEVEN_SEGMENT_MONITOR_TIMING_EN
  localparam int CNT_W = $clog2(COMPARE + TOLERANCE + 2);
  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(COMPARE - TOLERANCE);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(COMPARE + TOLERANCE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timing_q, timing_d, timing_set;

  // Interval counter: restarts at 1 on a change, otherwise counts up and saturates.
  always_comb begin
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    if (change_evt) cnt_d = CNT_W'(1);
  end

  // Timing flag: check completed intervals in TRACK and flag a stall once.
  always_comb begin
    timing_set = 1'b0;
    if (dec_legal && state_q == TRACK) begin
      if (change_evt) begin
        timing_set = in_seq && ((cnt_q < WIN_LO) || (cnt_q > WIN_HI));
      end else begin
        // This edge moves the count past the window: the change is overdue.
        timing_set = (cnt_q == WIN_HI);
      end
    end
    timing_d = timing_set | (timing_q & ~err_clear);
  end

  // Interval counter and timing flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      timing_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      timing_q <= timing_d;
    end
  end

  assign timing_error = timing_q;
`else
  assign timing_error = 1'b0;
`endif

endmodule
